// File: rtl/pattern_sequencer_if.sv
// Control, configuration and status bundle between the acquisition controller
// and the pattern sequencer; the sequencer implements the slave side.
interface pattern_sequencer_if #(
   parameter int SAMPLES_MAX = 128,
   parameter int OSF_MAX     = 8,
   parameter int FRAMES_W    = 8
);
   localparam int SW = $clog2(SAMPLES_MAX + 1);
   localparam int OW = $clog2(OSF_MAX + 1);

   logic                EN;
   logic                Start;
   logic                Stop;
   logic                Mode;
   logic [SW-1:0]       Samples_Cfg;
   logic [OW-1:0]       Osf_Cfg;
   logic [FRAMES_W-1:0] Frames_Cfg;

   logic                Busy;
   logic                Done;
   logic [OW-1:0]       Phase;
   logic [SW-1:0]       Sample_Idx;
   logic [FRAMES_W-1:0] Frame_Cnt;
   logic                Sample_Tick;
   logic                Frame_End;
   logic                Cfg_Err;

   modport master (
      output EN, Start, Stop, Mode, Samples_Cfg, Osf_Cfg, Frames_Cfg,
      input  Busy, Done, Phase, Sample_Idx, Frame_Cnt, Sample_Tick, Frame_End, Cfg_Err
   );

   modport slave (
      input  EN, Start, Stop, Mode, Samples_Cfg, Osf_Cfg, Frames_Cfg,
      output Busy, Done, Phase, Sample_Idx, Frame_Cnt, Sample_Tick, Frame_End, Cfg_Err
   );
endinterface

// File: rtl/pattern_sequencer.sv
// Oversampled sample/frame sequencer with one-shot and continuous modes.
// Every output is registered (one edge after the causing input); EN=0 freezes all counters.
module pattern_sequencer #(
   parameter int SAMPLES_MAX = 128,
   parameter int OSF_MAX     = 8,
   parameter int FRAMES_W    = 8
) (
   input  logic                    Clk,
   input  logic                    Reset,
   pattern_sequencer_if.slave      bus
);
   localparam int SW = $clog2(SAMPLES_MAX + 1);
   localparam int OW = $clog2(OSF_MAX + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [SW-1:0]       samples_l, samples_l_nxt, sample_idx, sample_idx_nxt;
   logic [OW-1:0]       osf_l, osf_l_nxt, phase, phase_nxt;
   logic [FRAMES_W-1:0] frames_l, frames_l_nxt, frame_cnt, frame_cnt_nxt;
   logic                mode_l, mode_l_nxt;
   logic                tick, tick_nxt, fend, fend_nxt, cerr, cerr_nxt;
   logic                busy, busy_nxt, done, done_nxt;
   logic                cfg_ok;

   assign cfg_ok = (bus.Samples_Cfg != '0) && (bus.Samples_Cfg <= SW'(SAMPLES_MAX)) &&
                   (bus.Osf_Cfg != '0) && (bus.Osf_Cfg <= OW'(OSF_MAX)) &&
                   (bus.Mode || (bus.Frames_Cfg != '0));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         samples_l  <= '0;
         osf_l      <= '0;
         frames_l   <= '0;
         mode_l     <= 1'b0;
         phase      <= '0;
         sample_idx <= '0;
         frame_cnt  <= '0;
         tick       <= 1'b0;
         fend       <= 1'b0;
         cerr       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         samples_l  <= samples_l_nxt;
         osf_l      <= osf_l_nxt;
         frames_l   <= frames_l_nxt;
         mode_l     <= mode_l_nxt;
         phase      <= phase_nxt;
         sample_idx <= sample_idx_nxt;
         frame_cnt  <= frame_cnt_nxt;
         tick       <= tick_nxt;
         fend       <= fend_nxt;
         cerr       <= cerr_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      samples_l_nxt  = samples_l;
      osf_l_nxt      = osf_l;
      frames_l_nxt   = frames_l;
      mode_l_nxt     = mode_l;
      phase_nxt      = phase;
      sample_idx_nxt = sample_idx;
      frame_cnt_nxt  = frame_cnt;
      tick_nxt       = 1'b0;
      fend_nxt       = 1'b0;
      cerr_nxt       = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (bus.Start) begin
               if (cfg_ok) begin
                  samples_l_nxt  = bus.Samples_Cfg;
                  osf_l_nxt      = bus.Osf_Cfg;
                  frames_l_nxt   = bus.Frames_Cfg;
                  mode_l_nxt     = bus.Mode;
                  phase_nxt      = '0;
                  sample_idx_nxt = '0;
                  frame_cnt_nxt  = '0;
                  state_nxt      = RUN;
               end else begin
                  cerr_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            // Stop suppresses any pulse that a coincident wrap would have produced.
            if (bus.Stop) begin
               state_nxt      = IDLE;
               phase_nxt      = '0;
               sample_idx_nxt = '0;
               frame_cnt_nxt  = '0;
            end else if (bus.EN) begin
               if (phase == osf_l - OW'(1)) begin
                  phase_nxt = '0;
                  tick_nxt  = 1'b1;
                  if (sample_idx == samples_l - SW'(1)) begin
                     sample_idx_nxt = '0;
                     fend_nxt       = 1'b1;
                     frame_cnt_nxt  = frame_cnt + FRAMES_W'(1);
                     if (!mode_l && (frame_cnt_nxt == frames_l))
                        state_nxt = DONE;
                  end else begin
                     sample_idx_nxt = sample_idx + SW'(1);
                  end
               end else begin
                  phase_nxt = phase + OW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
   end

   assign bus.Busy        = busy;
   assign bus.Done        = done;
   assign bus.Phase       = phase;
   assign bus.Sample_Idx  = sample_idx;
   assign bus.Frame_Cnt   = frame_cnt;
   assign bus.Sample_Tick = tick;
   assign bus.Frame_End   = fend;
   assign bus.Cfg_Err     = cerr;
endmodule
